alu_mul_seq: RTL

Multi-cycle unsigned shift-add multiplier that borrows the shared N-bit ALU for its additions. It sits beside the execute stage: the core issues a multiply with a start pulse, and the block runs the ALU add path once per set multiplier bit. It requests the ALU through a req/gnt pair, and the pipeline keeps priority. It returns a 2N-bit product with a one-cycle done pulse.

---
 rtl/alu_mul_seq.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: unsigned shift-add multiplier that borrows the shared ALU adder via req/gnt.
// Define MULSEQ_EARLY_EXIT_EN to finish as soon as no multiplier bits remain.
module alu_mul_seq #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] mcand,
    input  logic [N-1:0] mplr,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] prod_hi,
    output logic [N-1:0] prod_lo,
    output logic         alu_req,
    input  logic         alu_gnt,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [4:0]   alu_fn,
    input  logic [N-1:0] alu_r
);

    localparam int          CW     = $clog2(N) + 1;
    localparam logic [4:0]  FN_ADD = 5'b00001;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [N-1:0]   lo_q, lo_d;
    logic [N-1:0]   mc_q, mc_d;
    logic [N-1:0]   mp_q, mp_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   prod_hi_q, prod_hi_d;
    logic [N-1:0]   prod_lo_q, prod_lo_d;
    logic           carry;
    logic           iter_en;
`ifdef MULSEQ_EARLY_EXIT_EN
    logic [CW-1:0]  shamt;
`endif

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        lo_d      = lo_q;
        mc_d      = mc_q;
        mp_d      = mp_q;
        cnt_d     = cnt_q;
        prod_hi_d = prod_hi_q;
        prod_lo_d = prod_lo_q;
        busy      = 1'b0;
        done      = 1'b0;
        alu_req   = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_fn    = '0;
        carry     = 1'b0;
        iter_en   = 1'b0;
`ifdef MULSEQ_EARLY_EXIT_EN
        shamt     = CW'(N) - cnt_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mc_d    = mcand;
                    mp_d    = mplr;
                    acc_d   = '0;
                    lo_d    = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                busy = 1'b1;
`ifdef MULSEQ_EARLY_EXIT_EN
                // Remaining iterations would only shift in zeros; collapse them into one shift.
                if (mp_q == '0) begin
                    {acc_d, lo_d} = {acc_q, lo_q} >> shamt;
                    cnt_d         = CW'(N);
                    state_d       = S_DONE;
                end else
`endif
                if (mp_q[0]) begin
                    alu_req = 1'b1;
                    alu_a   = acc_q;
                    alu_b   = mc_q;
                    alu_fn  = FN_ADD;
                    if (alu_gnt) begin
                        // The ALU is only N bits wide; a wrapped sum reveals the carry-out.
                        carry         = (alu_r < acc_q);
                        {acc_d, lo_d} = {carry, alu_r, lo_q[N-1:1]};
                        iter_en       = 1'b1;
                    end
                end else begin
                    {acc_d, lo_d} = {1'b0, acc_q, lo_q[N-1:1]};
                    iter_en       = 1'b1;
                end

                if (iter_en) begin
                    mp_d  = mp_q >> 1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CW'(N)) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Product outputs move only when the final iteration lands.
        if (state_q == S_RUN && state_d == S_DONE) begin
            prod_hi_d = acc_d;
            prod_lo_d = lo_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            lo_q      <= '0;
            mc_q      <= '0;
            mp_q      <= '0;
            cnt_q     <= '0;
            prod_hi_q <= '0;
            prod_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            lo_q      <= lo_d;
            mc_q      <= mc_d;
            mp_q      <= mp_d;
            cnt_q     <= cnt_d;
            prod_hi_q <= prod_hi_d;
            prod_lo_q <= prod_lo_d;
        end
    end

    assign prod_hi = prod_hi_q;
    assign prod_lo = prod_lo_q;

endmodule
